if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of St.PU, directly upstream of ID.
- Owns the PC register, issues single-outstanding requests to instruction memory, and holds the IF/ID pipeline register that drives ID's pc_i/inst_i.
- Absorbs memory wait states, downstream stalls (via a one-entry skid buffer), branch redirects and exception flushes.

Parameters:
RESET_PC, 32'h0000_0000, PC after reset (word aligned)
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  fetch address; held stable while request pending
imem_ack_i  in  1  imem_rdata_i valid this cycle; completes request
imem_rdata_i  in  32  fetched instruction
stall_i  in  1  downstream stall; IF/ID register holds
branch_flag_i  in  1  taken branch from ID; sampled only when stall_i=0
branch_target_i  in  32  branch destination
flush_i  in  1  exception flush; overrides stall and branch
new_pc_i  in  32  flush destination
pc_o  out  32  IF/ID PC to ID
inst_o  out  32  IF/ID instruction to ID
inst_valid_o  out  1  IF/ID content is a real instruction

Behaviour:
- Reset (rst=0, async): state IDLE, pc=RESET_PC, pc_o=0, inst_o=0, inst_valid_o=0, imem_req_o=0, skid buffer empty, discard flag=0.
- imem_addr_o = pc register at all times; imem_req_o = 1 iff state REQ.
- FSM:
  - IDLE: no request; next edge -> REQ unconditionally.
  - REQ: request pending. Ack with no discard and (stall_i=0 or inst_valid_o=0) loads IF/ID {pc, rdata, valid=1}, pc+=PC_STEP, stays REQ. Ack while stall_i=1 and inst_valid_o=1 writes skid buffer {pc, rdata}, pc+=PC_STEP, -> BUF.
  - BUF: no request; when stall_i=0 load IF/ID from buffer, clear buffer, -> REQ.
- Zero-wait memory (ack in request cycle) gives 1 instruction/cycle. First inst_valid_o=1 appears 2 cycles after reset release.
- Without ack, when stall_i=0, IF/ID loads a bubble: inst_o=0, inst_valid_o=0, pc_o unchanged. When stall_i=1, IF/ID holds.
- Redirect, priority flush_i > branch_flag_i (branch only when stall_i=0); target = new_pc_i or branch_target_i with bits[1:0] forced to 00. No delay slot.
  - IF/ID becomes a bubble next edge, even if stall_i=1 for flush.
  - Skid buffer is cleared.
  - In REQ without same-cycle ack: address must not change mid-request. Set discard=1, latch target into pc-pending, stay REQ. The subsequent ack is dropped, pc=target, discard=0.
  - In REQ with same-cycle ack: data dropped; pc=target next edge; stays REQ.
  - In BUF or IDLE: pc=target; -> REQ.
- A second redirect while discard=1 overwrites the pending target. The later redirect wins.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- Reset asserted mid-request abandons it with no wait for ack. Memory must tolerate a dropped request.

Test Plan:
- Reset release, zero-wait memory returning addr as data -> imem_addr_o 0,4,8 on consecutive cycles; from cycle 2, inst_o=0,4,8 with pc_o equal and inst_valid_o=1.
- Ack delayed 3 cycles per request -> imem_addr_o stable for 3 cycles; bubbles (inst_valid_o=0) between instructions; no address skipped.
- stall_i=1 for 4 cycles during streaming -> IF/ID frozen, one extra inst buffered, state BUF, no request. After release, buffered inst appears next cycle and fetch resumes at the next PC with no loss or duplication.
- branch_flag_i=1, target 32'h0000_0103, in the cycle after request to 0x10 issued (ack 2 cycles later) -> 0x10 data dropped; next request addr 0x100; IF/ID bubble.
- flush_i=1, new_pc_i=32'h0000_0180, while stall_i=1 and in BUF -> buffer cleared, inst_valid_o=0 next edge, next request addr 0x180.
- RESET_PC=32'hFFFF_FFFC, zero-wait -> addresses FFFF_FFFC then 0000_0000; rst pulsed low mid-request -> all outputs at reset values immediately, restart from IDLE.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests,
// and holds the IF/ID register with a one-entry skid buffer for downstream stalls.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUF} state_t;

   state_t      r_state, w_state_nx;
   logic [31:0] r_pc, w_pc_nx;
   logic [31:0] r_pend, w_pend_nx;
   logic        r_discard, w_discard_nx;
   logic [31:0] r_id_pc, w_id_pc_nx;
   logic [31:0] r_id_inst, w_id_inst_nx;
   logic        r_id_vld, w_id_vld_nx;
   logic [31:0] r_buf_pc, w_buf_pc_nx;
   logic [31:0] r_buf_inst, w_buf_inst_nx;

   logic        w_redir;
   logic [31:0] w_redir_raw;
   logic [31:0] w_target;
   logic [31:0] w_pc_inc;
   logic        w_ld;
   logic [31:0] w_ld_pc;
   logic [31:0] w_ld_inst;

   // Flush overrides stall; a branch is only honoured when ID is advancing.
   assign w_redir     = flush_i | (branch_flag_i & ~stall_i);
   assign w_redir_raw = flush_i ? new_pc_i : branch_target_i;
   assign w_target    = {w_redir_raw[31:2], 2'b00};
   assign w_pc_inc    = r_pc + 32'(PC_STEP);

   always_comb begin
      w_state_nx    = r_state;
      w_pc_nx       = r_pc;
      w_pend_nx     = r_pend;
      w_discard_nx  = r_discard;
      w_buf_pc_nx   = r_buf_pc;
      w_buf_inst_nx = r_buf_inst;
      w_ld          = 1'b0;
      w_ld_pc       = r_pc;
      w_ld_inst     = imem_rdata_i;

      case (r_state)
         S_IDLE: begin
            w_state_nx = S_REQ;
            if (w_redir) w_pc_nx = w_target;
         end
         S_REQ: begin
            if (w_redir) begin
               // Address must stay put while the request is open, so park the target.
               if (imem_ack_i) begin
                  w_pc_nx      = w_target;
                  w_discard_nx = 1'b0;
               end else begin
                  w_pend_nx    = w_target;
                  w_discard_nx = 1'b1;
               end
            end else if (imem_ack_i) begin
               if (r_discard) begin
                  w_pc_nx      = r_pend;
                  w_discard_nx = 1'b0;
               end else begin
                  w_pc_nx = w_pc_inc;
                  if (stall_i && r_id_vld) begin
                     w_buf_pc_nx   = r_pc;
                     w_buf_inst_nx = imem_rdata_i;
                     w_state_nx    = S_BUF;
                  end else begin
                     w_ld = 1'b1;
                  end
               end
            end
         end
         S_BUF: begin
            if (w_redir) begin
               w_pc_nx    = w_target;
               w_state_nx = S_REQ;
            end else if (!stall_i) begin
               w_ld       = 1'b1;
               w_ld_pc    = r_buf_pc;
               w_ld_inst  = r_buf_inst;
               w_state_nx = S_REQ;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase

      w_id_pc_nx   = r_id_pc;
      w_id_inst_nx = r_id_inst;
      w_id_vld_nx  = r_id_vld;
      if (w_redir || (!w_ld && !stall_i)) begin
         w_id_inst_nx = 32'h0;
         w_id_vld_nx  = 1'b0;
      end else if (w_ld) begin
         w_id_pc_nx   = w_ld_pc;
         w_id_inst_nx = w_ld_inst;
         w_id_vld_nx  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_pend     <= 32'h0;
         r_discard  <= 1'b0;
         r_id_pc    <= 32'h0;
         r_id_inst  <= 32'h0;
         r_id_vld   <= 1'b0;
         r_buf_pc   <= 32'h0;
         r_buf_inst <= 32'h0;
      end else begin
         r_state    <= w_state_nx;
         r_pc       <= w_pc_nx;
         r_pend     <= w_pend_nx;
         r_discard  <= w_discard_nx;
         r_id_pc    <= w_id_pc_nx;
         r_id_inst  <= w_id_inst_nx;
         r_id_vld   <= w_id_vld_nx;
         r_buf_pc   <= w_buf_pc_nx;
         r_buf_inst <= w_buf_inst_nx;
      end
   end

   assign imem_req_o   = (r_state == S_REQ);
   assign imem_addr_o  = r_pc;
   assign pc_o         = r_id_pc;
   assign inst_o       = r_id_inst;
   assign inst_valid_o = r_id_vld;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run checked against an
// in-order instruction-stream model (expected next PC, redirect rules, stall hold).
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req, ack = 1'b0;
   logic [31:0] addr, rdata = 32'h0;
   logic        stall = 1'b0, br = 1'b0, fl = 1'b0;
   logic [31:0] bt = 32'h0, npc = 32'h0;
   logic [31:0] pc_o, inst_o;
   logic        vld;

   logic        req2, ack2, vld2;
   logic [31:0] addr2, rdata2, pc2, inst2;
   logic        z1 = 1'b0;
   logic [31:0] z32 = 32'h0;

   int checks = 0;
   int errors = 0;

   int          mem_wait = 0;
   bit          mem_rand = 1'b0;
   logic [31:0] mem_key  = 32'h0;
   int          mem_cnt  = 0;
   int          mem_lat  = 0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk(clk), .rst(rst), .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack),
      .imem_rdata_i(rdata), .stall_i(stall), .branch_flag_i(br), .branch_target_i(bt),
      .flush_i(fl), .new_pc_i(npc), .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(vld)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst(rst), .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(ack2),
      .imem_rdata_i(rdata2), .stall_i(z1), .branch_flag_i(z1), .branch_target_i(z32),
      .flush_i(z1), .new_pc_i(z32), .pc_o(pc2), .inst_o(inst2), .inst_valid_o(vld2)
   );

   // Zero-wait memory for the wrap instance: data equals address.
   assign ack2   = req2;
   assign rdata2 = addr2;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ mem_key;
   endfunction

   // Memory for the main instance: ack after mem_lat wait cycles, decided mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         ack = 1'b0; mem_cnt = 0;
      end else if (req) begin
         if (mem_cnt == 0) mem_lat = mem_rand ? int'($urandom_range(mem_wait)) : mem_wait;
         if (mem_cnt >= mem_lat) begin
            ack = 1'b1; rdata = memf(addr); mem_cnt = 0;
         end else begin
            ack = 1'b0; rdata = $urandom; mem_cnt++;
         end
      end else begin
         ack = 1'b0; mem_cnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; stall = 1'b0; br = 1'b0; fl = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({req, addr, vld, pc_o, inst_o} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
         errors++; $display("FAIL reset_main: got %h expected %h", {req, addr, vld, pc_o, inst_o}, {1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
      end
      checks++;
      if ({req2, addr2, vld2} !== {1'b0, 32'hFFFF_FFFC, 1'b0}) begin
         errors++; $display("FAIL reset_wrap: got %h expected %h", {req2, addr2, vld2}, {1'b0, 32'hFFFF_FFFC, 1'b0});
      end
   endtask

   task automatic test_stream();
      mem_wait = 0; mem_rand = 0; mem_key = 32'h0;
      do_reset();
      tick();
      checks++;
      if ({req, addr, vld} !== {1'b1, 32'h0, 1'b0}) begin
         errors++; $display("FAIL stream_first_req: got %h expected %h", {req, addr, vld}, {1'b1, 32'h0, 1'b0});
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({vld, pc_o, inst_o, addr} !== {1'b1, 32'(4*i), 32'(4*i), 32'(4*(i+1))}) begin
            errors++; $display("FAIL stream_%0d: got %h expected %h", i, {vld, pc_o, inst_o, addr}, {1'b1, 32'(4*i), 32'(4*i), 32'(4*(i+1))});
         end
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] exp = 32'h0;
      int n = 0;
      mem_wait = 2; mem_rand = 0; mem_key = 32'h1234_0000;
      do_reset();
      for (int c = 1; c <= 30; c++) begin
         logic evld;
         tick();
         evld = (c >= 4) && ((c - 4) % 3 == 0);
         checks++;
         if ({req, addr, vld} !== {1'b1, 32'(4*((c-1)/3)), evld}) begin
            errors++; $display("FAIL wait_cycle_%0d: got %h expected %h", c, {req, addr, vld}, {1'b1, 32'(4*((c-1)/3)), evld});
         end
         if (vld) begin
            checks++;
            if ({pc_o, inst_o} !== {exp, memf(exp)}) begin
               errors++; $display("FAIL wait_inst: got %h expected %h", {pc_o, inst_o}, {exp, memf(exp)});
            end
            exp += 4; n++;
         end
      end
      checks++;
      if (n != 9) begin errors++; $display("FAIL wait_count: got %0d expected 9", n); end
   endtask

   task automatic test_stall();
      mem_wait = 0; mem_rand = 0; mem_key = 32'hBEEF_0000;
      do_reset();
      repeat (4) tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); stall = 1'b1;
         tick();
         checks++;
         if ({req, vld, pc_o, inst_o, addr} !== {1'b0, 1'b1, 32'h8, memf(32'h8), 32'h10}) begin
            errors++; $display("FAIL stall_hold_%0d: got %h expected %h", k, {req, vld, pc_o, inst_o, addr}, {1'b0, 1'b1, 32'h8, memf(32'h8), 32'h10});
         end
      end
      @(negedge clk); stall = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if ({req, vld, pc_o, inst_o, addr} !== {1'b1, 1'b1, 32'(12+4*k), memf(32'(12+4*k)), 32'(16+4*k)}) begin
            errors++; $display("FAIL stall_release_%0d: got %h expected %h", k, {req, vld, pc_o, inst_o, addr}, {1'b1, 1'b1, 32'(12+4*k), memf(32'(12+4*k)), 32'(16+4*k)});
         end
      end
   endtask

   task automatic test_branch();
      bit found = 0;
      bit got = 0;
      mem_wait = 2; mem_rand = 0; mem_key = 32'h00AA_5500;
      do_reset();
      for (int c = 0; c < 40 && !found; c++) begin
         tick();
         if (req && addr == 32'h10) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL branch_reach_0x10: got timeout expected addr 10"); end
      tick();
      @(negedge clk); br = 1'b1; bt = 32'h0000_0103;
      tick();
      checks++;
      if ({vld, req, addr} !== {1'b0, 1'b1, 32'h10}) begin
         errors++; $display("FAIL branch_hold_addr: got %h expected %h", {vld, req, addr}, {1'b0, 1'b1, 32'h10});
      end
      @(negedge clk); br = 1'b0;
      tick();
      checks++;
      if ({vld, req, addr} !== {1'b0, 1'b1, 32'h100}) begin
         errors++; $display("FAIL branch_new_addr: got %h expected %h", {vld, req, addr}, {1'b0, 1'b1, 32'h100});
      end
      for (int c = 0; c < 10 && !got; c++) begin
         tick();
         if (vld) got = 1;
      end
      checks++;
      if (!got || {pc_o, inst_o} !== {32'h100, memf(32'h100)}) begin
         errors++; $display("FAIL branch_target_inst: got %h expected %h", {pc_o, inst_o}, {32'h100, memf(32'h100)});
      end
   endtask

   task automatic test_flush_buf();
      mem_wait = 0; mem_rand = 0; mem_key = 32'h7777_0000;
      do_reset();
      repeat (3) tick();
      @(negedge clk); stall = 1'b1;
      tick();
      checks++;
      if ({req, vld, pc_o} !== {1'b0, 1'b1, 32'h4}) begin
         errors++; $display("FAIL flush_enter_buf: got %h expected %h", {req, vld, pc_o}, {1'b0, 1'b1, 32'h4});
      end
      @(negedge clk); fl = 1'b1; npc = 32'h0000_0180;
      tick();
      checks++;
      if ({vld, inst_o, req, addr} !== {1'b0, 32'h0, 1'b1, 32'h180}) begin
         errors++; $display("FAIL flush_bubble: got %h expected %h", {vld, inst_o, req, addr}, {1'b0, 32'h0, 1'b1, 32'h180});
      end
      @(negedge clk); fl = 1'b0; stall = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if ({vld, pc_o, inst_o} !== {1'b1, 32'(32'h180+4*k), memf(32'(32'h180+4*k))}) begin
            errors++; $display("FAIL flush_resume_%0d: got %h expected %h", k, {vld, pc_o, inst_o}, {1'b1, 32'(32'h180+4*k), memf(32'(32'h180+4*k))});
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      tick();
      checks++;
      if ({req2, addr2, vld2} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
         errors++; $display("FAIL wrap_first_req: got %h expected %h", {req2, addr2, vld2}, {1'b1, 32'hFFFF_FFFC, 1'b0});
      end
      tick();
      checks++;
      if ({vld2, pc2, inst2, addr2} !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0}) begin
         errors++; $display("FAIL wrap_top: got %h expected %h", {vld2, pc2, inst2, addr2}, {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0});
      end
      tick();
      checks++;
      if ({vld2, pc2, inst2, addr2} !== {1'b1, 32'h0, 32'h0, 32'h4}) begin
         errors++; $display("FAIL wrap_zero: got %h expected %h", {vld2, pc2, inst2, addr2}, {1'b1, 32'h0, 32'h0, 32'h4});
      end
   endtask

   task automatic test_reset_mid();
      bit got = 0;
      mem_wait = 3; mem_rand = 0; mem_key = 32'h0F0F_0000;
      do_reset();
      repeat (2) tick();
      #3 rst = 1'b0;
      #1;
      checks++;
      if ({req, addr, vld, pc_o, inst_o, req2, addr2, vld2} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b0}) begin
         errors++; $display("FAIL reset_mid: got %h expected %h", {req, addr, vld, pc_o, inst_o, req2, addr2, vld2}, {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b0});
      end
      @(negedge clk); rst = 1'b1;
      tick();
      checks++;
      if ({req, addr, vld} !== {1'b1, 32'h0, 1'b0}) begin
         errors++; $display("FAIL reset_mid_restart: got %h expected %h", {req, addr, vld}, {1'b1, 32'h0, 1'b0});
      end
      for (int c = 0; c < 10 && !got; c++) begin
         tick();
         if (vld) got = 1;
      end
      checks++;
      if (!got || {pc_o, inst_o} !== {32'h0, memf(32'h0)}) begin
         errors++; $display("FAIL reset_mid_first_inst: got %h expected %h", {pc_o, inst_o}, {32'h0, memf(32'h0)});
      end
   endtask

   // Model: instructions reach ID strictly in program order from the last redirect target.
   task automatic test_random();
      logic [31:0] exp = 32'h0;
      int n = 0;
      mem_wait = 3; mem_rand = 1; mem_key = $urandom;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic p_vld, p_req, p_ack, redir;
         logic [31:0] p_pc, p_inst, p_addr, tgt;
         @(negedge clk);
         stall = ($urandom_range(99) < 35);
         fl    = ($urandom_range(99) < 4);
         br    = ($urandom_range(99) < 8);
         bt    = $urandom;
         npc   = $urandom;
         #1;
         p_vld = vld; p_pc = pc_o; p_inst = inst_o;
         p_req = req; p_ack = ack; p_addr = addr;
         redir = fl | (br & ~stall);
         tgt   = fl ? npc : bt;
         tgt[1:0] = 2'b00;
         tick();
         checks++;
         if (redir) begin
            if ({vld, inst_o, pc_o} !== {1'b0, 32'h0, p_pc}) begin
               errors++; $display("FAIL rand_redirect c%0d: got %h expected %h", c, {vld, inst_o, pc_o}, {1'b0, 32'h0, p_pc});
            end
            exp = tgt;
         end else if (stall && p_vld) begin
            if ({vld, pc_o, inst_o} !== {1'b1, p_pc, p_inst}) begin
               errors++; $display("FAIL rand_hold c%0d: got %h expected %h", c, {vld, pc_o, inst_o}, {1'b1, p_pc, p_inst});
            end
         end else if (vld) begin
            if ({pc_o, inst_o} !== {exp, memf(exp)}) begin
               errors++; $display("FAIL rand_order c%0d: got %h expected %h", c, {pc_o, inst_o}, {exp, memf(exp)});
            end
            exp += 4; n++;
         end else begin
            if ({inst_o, pc_o} !== {32'h0, p_pc}) begin
               errors++; $display("FAIL rand_bubble c%0d: got %h expected %h", c, {inst_o, pc_o}, {32'h0, p_pc});
            end
         end
         if (p_req && !p_ack) begin
            checks++;
            if ({req, addr} !== {1'b1, p_addr}) begin
               errors++; $display("FAIL rand_addr_stable c%0d: got %h expected %h", c, {req, addr}, {1'b1, p_addr});
            end
         end
      end
      @(negedge clk); stall = 1'b0; br = 1'b0; fl = 1'b0;
      checks++;
      if (n < 20) begin errors++; $display("FAIL rand_progress: got %0d delivered expected at least 20", n); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_wait_states();
      test_stall();
      test_branch();
      test_flush_buf();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
